// File: rtl/libmm_xlat_arb_if.sv
// Stream bundle for libmm_xlat_arb: two translated-request inputs and one tagged output.
// The slave modport is the arbiter's view; master is the environment's view.
interface libmm_xlat_arb_if #(
  parameter int unsigned DATA_W = 48
);
  logic [DATA_W-1:0] in_rd_tdata;
  logic              in_rd_tvalid;
  logic              in_rd_tready;
  logic [DATA_W-1:0] in_wr_tdata;
  logic              in_wr_tvalid;
  logic              in_wr_tready;
  logic [DATA_W:0]   out_tdata;
  logic              out_tvalid;
  logic              out_tready;

  modport slave (
    input  in_rd_tdata, in_rd_tvalid, output in_rd_tready,
    input  in_wr_tdata, in_wr_tvalid, output in_wr_tready,
    output out_tdata, out_tvalid, input out_tready
  );

  modport master (
    output in_rd_tdata, in_rd_tvalid, input in_rd_tready,
    output in_wr_tdata, in_wr_tvalid, input in_wr_tready,
    input  out_tdata, out_tvalid, output out_tready
  );
endinterface

// File: rtl/libmm_xlat_arb.sv
// Merges read/write translated-request streams through per-channel FIFOs and a weighted
// round-robin arbiter into one tagged stream. Optional counters: LIBMM_XARB_STATS_EN.
module libmm_xlat_arb #(
  parameter int unsigned DATA_W     = 48,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RD_WEIGHT  = 1,
  parameter int unsigned WR_WEIGHT  = 1
) (
  input  logic            ap_clk,
  input  logic            ap_rst_n,
  libmm_xlat_arb_if.slave bus
`ifdef LIBMM_XARB_STATS_EN
  ,
  input  logic            stat_clr,
  output logic [31:0]     stat_rd_cnt,
  output logic [31:0]     stat_wr_cnt
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullCnt = CW'(FIFO_DEPTH);
  localparam logic [3:0] RdWeight = 4'(RD_WEIGHT);
  localparam logic [3:0] WrWeight = 4'(WR_WEIGHT);

  // Channel index 0 is read, 1 is write; it doubles as the output tag bit.
  logic [DATA_W-1:0] mem_q [2][FIFO_DEPTH];
  logic [AW-1:0]     wptr_q [2];
  logic [AW-1:0]     wptr_d [2];
  logic [AW-1:0]     rptr_q [2];
  logic [AW-1:0]     rptr_d [2];
  logic [CW-1:0]     cnt_q  [2];
  logic [CW-1:0]     cnt_d  [2];
  logic [DATA_W-1:0] in_data [2];
  logic [1:0]        in_valid, in_rdy, push, pop, not_empty;

  logic              rdy_en_q;
  logic              cur_q, cur_d;
  logic [3:0]        credit_q, credit_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W:0]   out_data_q, out_data_d;
  logic              load, grant_vld, grant_ch;
  logic [3:0]        cur_weight;

  always_comb begin
    in_valid   = {bus.in_wr_tvalid, bus.in_rd_tvalid};
    in_data[0] = bus.in_rd_tdata;
    in_data[1] = bus.in_wr_tdata;
    for (int c = 0; c < 2; c++) begin
      // Readiness uses only the registered count, so a full FIFO refuses even on a pop cycle.
      in_rdy[c]    = rdy_en_q && (cnt_q[c] < FullCnt);
      push[c]      = in_valid[c] && in_rdy[c];
      not_empty[c] = (cnt_q[c] != '0);
    end
  end

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      wptr_d[c] = wptr_q[c] + AW'(push[c]);
      rptr_d[c] = rptr_q[c] + AW'(pop[c]);
      cnt_d[c]  = cnt_q[c] + CW'(push[c]) - CW'(pop[c]);
    end
  end

  always_comb begin
    load        = !out_valid_q || bus.out_tready;
    cur_weight  = cur_q ? WrWeight : RdWeight;
    grant_vld   = 1'b0;
    grant_ch    = cur_q;
    pop         = '0;
    cur_d       = cur_q;
    credit_d    = credit_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (load) begin
      if (not_empty[0] && not_empty[1]) begin
        grant_vld = 1'b1;
        grant_ch  = (credit_q < cur_weight) ? cur_q : !cur_q;
      end else if (not_empty[0]) begin
        grant_vld = 1'b1;
        grant_ch  = 1'b0;
      end else if (not_empty[1]) begin
        grant_vld = 1'b1;
        grant_ch  = 1'b1;
      end
      out_valid_d = grant_vld;
      if (grant_vld) begin
        pop[grant_ch] = 1'b1;
        out_data_d    = {grant_ch, mem_q[grant_ch][rptr_q[grant_ch]]};
        if (grant_ch == cur_q) begin
          // Saturate so a long solo run cannot wrap back below the weight.
          credit_d = (credit_q == 4'hF) ? credit_q : credit_q + 4'd1;
        end else begin
          cur_d    = grant_ch;
          credit_d = 4'd1;
        end
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rdy_en_q    <= 1'b0;
      cur_q       <= 1'b0;
      credit_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int c = 0; c < 2; c++) begin
        wptr_q[c] <= '0;
        rptr_q[c] <= '0;
        cnt_q[c]  <= '0;
      end
    end else begin
      rdy_en_q    <= 1'b1;
      cur_q       <= cur_d;
      credit_q    <= credit_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      for (int c = 0; c < 2; c++) begin
        wptr_q[c] <= wptr_d[c];
        rptr_q[c] <= rptr_d[c];
        cnt_q[c]  <= cnt_d[c];
      end
    end
  end

  // Storage needs no reset; the flushed pointers make stale entries unreachable.
  always_ff @(posedge ap_clk) begin
    for (int c = 0; c < 2; c++) begin
      if (push[c]) begin
        mem_q[c][wptr_q[c]] <= in_data[c];
      end
    end
  end

  assign bus.in_rd_tready = in_rdy[0];
  assign bus.in_wr_tready = in_rdy[1];
  assign bus.out_tvalid   = out_valid_q;
  assign bus.out_tdata    = out_data_q;

`ifdef LIBMM_XARB_STATS_EN
  logic [31:0] stat_rd_q, stat_rd_d, stat_wr_q, stat_wr_d;
  logic        xfer;

  always_comb begin
    xfer      = out_valid_q && bus.out_tready;
    stat_rd_d = stat_rd_q;
    stat_wr_d = stat_wr_q;
    if (stat_clr) begin
      stat_rd_d = '0;
      stat_wr_d = '0;
    end else if (xfer) begin
      if (out_data_q[DATA_W]) begin
        stat_wr_d = stat_wr_q + 32'd1;
      end else begin
        stat_rd_d = stat_rd_q + 32'd1;
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      stat_rd_q <= '0;
      stat_wr_q <= '0;
    end else begin
      stat_rd_q <= stat_rd_d;
      stat_wr_q <= stat_wr_d;
    end
  end

  assign stat_rd_cnt = stat_rd_q;
  assign stat_wr_cnt = stat_wr_q;
`endif

endmodule

// File: tb/tb_libmm_xlat_arb.sv
// Scoreboard bench for libmm_xlat_arb: default-weight instance plus an RD_WEIGHT=3 instance.
// Stats checks are compiled in when LIBMM_XARB_STATS_EN is defined.
module tb_libmm_xlat_arb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail = 0;

  libmm_xlat_arb_if #(.DATA_W(48)) bus0 ();
  libmm_xlat_arb_if #(.DATA_W(48)) bus1 ();

`ifdef LIBMM_XARB_STATS_EN
  logic        stat_clr0 = 1'b0;
  logic        stat_clr1 = 1'b0;
  logic [31:0] stat_rd0, stat_wr0, stat_rd1, stat_wr1;
`endif

  libmm_xlat_arb #(.DATA_W(48), .FIFO_DEPTH(4), .RD_WEIGHT(1), .WR_WEIGHT(1)) u_dut0 (
    .ap_clk   (clk),
    .ap_rst_n (rst_n),
    .bus      (bus0)
`ifdef LIBMM_XARB_STATS_EN
    ,
    .stat_clr    (stat_clr0),
    .stat_rd_cnt (stat_rd0),
    .stat_wr_cnt (stat_wr0)
`endif
  );

  libmm_xlat_arb #(.DATA_W(48), .FIFO_DEPTH(4), .RD_WEIGHT(3), .WR_WEIGHT(1)) u_dut1 (
    .ap_clk   (clk),
    .ap_rst_n (rst_n),
    .bus      (bus1)
`ifdef LIBMM_XARB_STATS_EN
    ,
    .stat_clr    (stat_clr1),
    .stat_rd_cnt (stat_rd1),
    .stat_wr_cnt (stat_wr1)
`endif
  );

  logic [47:0] q0_rd[$], q0_wr[$], q1_rd[$], q1_wr[$];
  logic [48:0] exp0[$], exp1[$];
  int acc0_rd = 0;
  int acc0_rd_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic drain(input int which, input string name);
    for (int i = 0; i < 100; i++) begin
      if ((which == 0 ? exp0.size() : exp1.size()) == 0) break;
      @(negedge clk);
    end
    chk(name, (which == 0) ? exp0.size() : exp1.size(), 0);
  endtask

  // Drivers present the queue head and retire it once the handshake edge has passed.
  initial begin : drv0
    bit acc_r, acc_w;
    bus0.in_rd_tvalid = 1'b0; bus0.in_rd_tdata = '0;
    bus0.in_wr_tvalid = 1'b0; bus0.in_wr_tdata = '0;
    forever begin
      @(negedge clk);
      acc_r = bus0.in_rd_tvalid && bus0.in_rd_tready;
      acc_w = bus0.in_wr_tvalid && bus0.in_wr_tready;
      @(posedge clk);
      #1;
      if (acc_r && q0_rd.size() != 0) begin q0_rd.delete(0); acc0_rd++; acc0_rd_cyc = cyc; end
      if (acc_w && q0_wr.size() != 0) q0_wr.delete(0);
      bus0.in_rd_tvalid = (q0_rd.size() != 0);
      if (q0_rd.size() != 0) bus0.in_rd_tdata = q0_rd[0];
      bus0.in_wr_tvalid = (q0_wr.size() != 0);
      if (q0_wr.size() != 0) bus0.in_wr_tdata = q0_wr[0];
    end
  end

  initial begin : drv1
    bit acc_r, acc_w;
    bus1.in_rd_tvalid = 1'b0; bus1.in_rd_tdata = '0;
    bus1.in_wr_tvalid = 1'b0; bus1.in_wr_tdata = '0;
    forever begin
      @(negedge clk);
      acc_r = bus1.in_rd_tvalid && bus1.in_rd_tready;
      acc_w = bus1.in_wr_tvalid && bus1.in_wr_tready;
      @(posedge clk);
      #1;
      if (acc_r && q1_rd.size() != 0) q1_rd.delete(0);
      if (acc_w && q1_wr.size() != 0) q1_wr.delete(0);
      bus1.in_rd_tvalid = (q1_rd.size() != 0);
      if (q1_rd.size() != 0) bus1.in_rd_tdata = q1_rd[0];
      bus1.in_wr_tvalid = (q1_wr.size() != 0);
      if (q1_wr.size() != 0) bus1.in_wr_tdata = q1_wr[0];
    end
  end

  // Monitors: a held beat must already equal the next expected beat; a transfer pops it.
  initial begin : mon0
    forever begin
      @(negedge clk);
      if (rst_n && bus0.out_tvalid) begin
        if (exp0.size() == 0) begin
          chk("dut0_unexpected_beat", bus0.out_tdata, 49'h0);
        end else if (bus0.out_tready) begin
          chk("dut0_order", bus0.out_tdata, exp0[0]);
          exp0.delete(0);
        end else begin
          chk("dut0_held_stable", bus0.out_tdata, exp0[0]);
        end
      end
    end
  end

  initial begin : mon1
    forever begin
      @(negedge clk);
      if (rst_n && bus1.out_tvalid) begin
        if (exp1.size() == 0) begin
          chk("dut1_unexpected_beat", bus1.out_tdata, 49'h0);
        end else if (bus1.out_tready) begin
          chk("dut1_order", bus1.out_tdata, exp1[0]);
          exp1.delete(0);
        end else begin
          chk("dut1_held_stable", bus1.out_tdata, exp1[0]);
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [47:0] r, w;
    bit seen;
    bus0.out_tready = 1'b1;
    bus1.out_tready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_tvalid", bus0.out_tvalid, 0);
    chk("rst_out_tdata", bus0.out_tdata, 0);
    chk("rst_rd_tready", bus0.in_rd_tready, 0);
    chk("rst_wr_tready", bus0.in_wr_tready, 0);
    chk("rst_dut1_rd_tready", bus1.in_rd_tready, 0);
`ifdef LIBMM_XARB_STATS_EN
    chk("rst_stat_rd", stat_rd0, 0);
    chk("rst_stat_wr", stat_wr0, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rd_tready", bus0.in_rd_tready, 1);
    chk("post_rst_wr_tready", bus0.in_wr_tready, 1);
    chk("post_rst_out_tvalid", bus0.out_tvalid, 0);

    // Contended fairness on dut0: preload under back-pressure, then release.
    @(posedge clk); #1;
    bus0.out_tready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      r = 48'h0000_AAAA_0000 + 48'(i);
      w = 48'h0000_BBBB_0000 + 48'(i);
      q0_rd.push_back(r);
      q0_wr.push_back(w);
      exp0.push_back({1'b0, r});
      exp0.push_back({1'b1, w});
    end
    repeat (12) @(posedge clk);
    #1;
    bus0.out_tready = 1'b1;
    drain(0, "fair_drain");

    // Weighting on dut1 (RD_WEIGHT=3): R0 R1 R2 W0 R3 R4 R5 W1.
    @(negedge clk);
    for (int i = 0; i < 6; i++) q1_rd.push_back(48'h0000_C000_0000 + 48'(i));
    for (int i = 0; i < 2; i++) q1_wr.push_back(48'h0000_D000_0000 + 48'(i));
    exp1.push_back({1'b0, 48'h0000_C000_0000});
    exp1.push_back({1'b0, 48'h0000_C000_0001});
    exp1.push_back({1'b0, 48'h0000_C000_0002});
    exp1.push_back({1'b1, 48'h0000_D000_0000});
    exp1.push_back({1'b0, 48'h0000_C000_0003});
    exp1.push_back({1'b0, 48'h0000_C000_0004});
    exp1.push_back({1'b0, 48'h0000_C000_0005});
    exp1.push_back({1'b1, 48'h0000_D000_0001});
    repeat (12) @(posedge clk);
    #1;
    bus1.out_tready = 1'b1;
    drain(1, "weight_drain");

    // Single-channel latency: accepted at edge N, visible after edge N+1, for one cycle.
    @(negedge clk);
    q0_rd.push_back(48'h0000_1234_5678);
    exp0.push_back(49'h0_0000_1234_5678);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus0.out_tvalid) begin seen = 1'b1; break; end
    end
    chk("lat_seen", seen, 1);
    chk("lat_cycles", cyc - acc0_rd_cyc, 1);
    @(negedge clk);
    chk("lat_one_cycle", bus0.out_tvalid, 0);

    // Back-pressure and full: 5 beats accepted, then a gap-free drain.
    @(posedge clk); #1;
    bus0.out_tready = 1'b0;
    @(negedge clk);
    acc0_rd = 0;
    for (int i = 0; i < 6; i++) begin
      q0_rd.push_back(48'h0000_EEEE_0000 + 48'(i));
      exp0.push_back({1'b0, 48'h0000_EEEE_0000 + 48'(i)});
    end
    repeat (12) @(negedge clk);
    chk("bp_accepted", acc0_rd, 5);
    chk("bp_rd_tready", bus0.in_rd_tready, 0);
    @(posedge clk); #1;
    bus0.out_tready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("bp_no_gap", bus0.out_tvalid, 1);
    end
    drain(0, "bp_drain");

`ifdef LIBMM_XARB_STATS_EN
    @(posedge clk); #1;
    stat_clr0 = 1'b1;
    @(posedge clk); #1;
    stat_clr0 = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      q0_rd.push_back(48'h0000_5555_0000 + 48'(i));
      exp0.push_back({1'b0, 48'h0000_5555_0000 + 48'(i)});
    end
    drain(0, "stat_rd_drain");
    for (int i = 0; i < 2; i++) begin
      q0_wr.push_back(48'h0000_6666_0000 + 48'(i));
      exp0.push_back({1'b1, 48'h0000_6666_0000 + 48'(i)});
    end
    drain(0, "stat_wr_drain");
    @(negedge clk);
    chk("stat_rd_cnt", stat_rd0, 3);
    chk("stat_wr_cnt", stat_wr0, 2);
    // Clear coincides with a read transfer; clear wins.
    @(posedge clk); #1;
    bus0.out_tready = 1'b0;
    @(negedge clk);
    q0_rd.push_back(48'h0000_7777_0000);
    exp0.push_back({1'b0, 48'h0000_7777_0000});
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus0.out_tvalid) begin seen = 1'b1; break; end
    end
    chk("stat_clr_seen", seen, 1);
    @(posedge clk); #1;
    bus0.out_tready = 1'b1;
    stat_clr0 = 1'b1;
    @(posedge clk); #1;
    stat_clr0 = 1'b0;
    @(negedge clk);
    chk("stat_clr_rd", stat_rd0, 0);
    chk("stat_clr_wr", stat_wr0, 0);
    drain(0, "stat_clr_drain");
`endif

    // Mid-operation reset flushes FIFOs and the held output beat.
    @(posedge clk); #1;
    bus0.out_tready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      q0_rd.push_back(48'h0000_F000_0000 + 48'(i));
      exp0.push_back({1'b0, 48'h0000_F000_0000 + 48'(i)});
    end
    repeat (12) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    q0_rd.delete();
    exp0.delete();
    @(negedge clk);
    chk("flush_out_tvalid", bus0.out_tvalid, 0);
    chk("flush_rd_tready", bus0.in_rd_tready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus0.out_tready = 1'b1;
    repeat (3) @(negedge clk);
    chk("flush_no_stale_beat", bus0.out_tvalid, 0);
    chk("flush_out_tdata", bus0.out_tdata, 0);
    chk("flush_rd_tready_back", bus0.in_rd_tready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
